// File: rtl/secure_reg_file.sv
// Purpose: CPU register file with two combinational read ports and one write port.
//   The upper protected registers accept writes only from the privileged user ID.
//   Refused protected writes feed a violation counter and a lockout FSM with a
//   privileged unlock followed by a fixed cooldown.
// Latency: reads are combinational. An accepted write commits at the next CLK edge.
//   WR_ACK or WR_DENY is a registered pulse in the cycle after the write.
// Backpressure: none. A write is accepted, denied or ignored in its own cycle and never stalls.
// Ports:
//   CLK, RST_N                     clock (rising edge), asynchronous active-low reset
//   RF_ADR1, RF_ADR2, RF_RS1/2     two combinational read ports
//   RF_WA, RF_EN, RF_WD            write port
//   U_ID, UNLOCK                   current user ID; unlock request
//   WR_ACK, WR_DENY                one-cycle write outcome pulses
//   VIOL_CNT, LOCKED               security monitor outputs
module secure_reg_file #(
  parameter int DW           = 16,
  parameter int DEPTH        = 16,
  parameter int IDW          = 16,
  parameter int PROT_BASE    = 13,
  parameter int PRIV_ID      = 31,
  parameter int MAX_VIOL     = 3,
  parameter int COOLDOWN_CYC = 4,
  parameter int BYPASS       = 1,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic [AW-1:0]  RF_ADR1,
  input  logic [AW-1:0]  RF_ADR2,
  input  logic [AW-1:0]  RF_WA,
  input  logic           RF_EN,
  input  logic [DW-1:0]  RF_WD,
  input  logic [IDW-1:0] U_ID,
  input  logic           UNLOCK,
  output logic [DW-1:0]  RF_RS1,
  output logic [DW-1:0]  RF_RS2,
  output logic           WR_ACK,
  output logic           WR_DENY,
  output logic [3:0]     VIOL_CNT,
  output logic           LOCKED
);

  localparam int         CDW  = $clog2(COOLDOWN_CYC + 1);
  localparam logic [3:0] MAXV = 4'(MAX_VIOL);

  typedef enum logic [1:0] {
    ST_OPEN,
    ST_LOCKED,
    ST_COOLDOWN
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     viol_q, viol_d;
  logic [CDW-1:0] cd_q, cd_d;
  logic [DW-1:0]  mem_q [DEPTH];

  logic priv;
  logic open_priv;
  logic wa_ok;
  logic wa_prot;
  logic wr_acc;
  logic wr_den;
  logic viol_evt;
  logic byp1;
  logic byp2;

  // A read address is visible unless it is register 0, out of range, or a
  // protected register while the reader lacks privilege or the FSM is not OPEN.
  function automatic logic rd_ok(input logic [AW-1:0] adr, input logic prot_open);
    return (adr != '0) && (int'(adr) < DEPTH) &&
           ((int'(adr) < PROT_BASE) || prot_open);
  endfunction

  assign priv      = (U_ID == IDW'(PRIV_ID));
  assign open_priv = priv && (state_q == ST_OPEN);

  // Register 0 and out-of-range addresses drop the write silently: no ACK, no DENY.
  assign wa_ok   = (RF_WA != '0) && (int'(RF_WA) < DEPTH);
  assign wa_prot = (int'(RF_WA) >= PROT_BASE);

  assign wr_acc = RF_EN && wa_ok && (!wa_prot || open_priv);
  assign wr_den = RF_EN && wa_ok && wa_prot && !open_priv;
  // A refusal in OPEN can only come from a missing privilege, so it counts as a violation.
  // Refusals in LOCKED or COOLDOWN are not counted.
  assign viol_evt = wr_den && (state_q == ST_OPEN);

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_acc) begin
      mem_q[RF_WA] <= RF_WD;
    end
  end

  // ---------------------------------------------------------------------------
  // Lockout FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_OPEN;
      viol_q  <= '0;
      cd_q    <= '0;
    end else begin
      state_q <= state_d;
      viol_q  <= viol_d;
      cd_q    <= cd_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Lockout FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    viol_d  = viol_q;
    cd_d    = cd_q;
    unique case (state_q)
      ST_OPEN: begin
        if (viol_evt) begin
          if (viol_q != MAXV) begin
            viol_d = viol_q + 4'd1;
          end
          if ((viol_q + 4'd1) == MAXV) begin
            state_d = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        if (UNLOCK && priv) begin
          state_d = ST_COOLDOWN;
          cd_d    = CDW'(COOLDOWN_CYC);
        end
      end
      ST_COOLDOWN: begin
        // The counter is loaded with COOLDOWN_CYC on entry. Leaving when it reads 1
        // gives exactly COOLDOWN_CYC cycles in this state.
        if (cd_q == CDW'(1)) begin
          state_d = ST_OPEN;
          viol_d  = '0;
          cd_d    = '0;
        end else begin
          cd_d = cd_q - CDW'(1);
        end
      end
      default: begin
        state_d = ST_OPEN;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write outcome pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      WR_ACK  <= 1'b0;
      WR_DENY <= 1'b0;
    end else begin
      WR_ACK  <= wr_acc;
      WR_DENY <= wr_den;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  // Only an accepted write is forwarded, so a denied write can never leak its data.
  assign byp1 = (BYPASS != 0) && wr_acc && (RF_WA == RF_ADR1);
  assign byp2 = (BYPASS != 0) && wr_acc && (RF_WA == RF_ADR2);

  always_comb begin
    RF_RS1 = '0;
    if (rd_ok(RF_ADR1, open_priv)) begin
      RF_RS1 = byp1 ? RF_WD : mem_q[RF_ADR1];
    end
  end

  always_comb begin
    RF_RS2 = '0;
    if (rd_ok(RF_ADR2, open_priv)) begin
      RF_RS2 = byp2 ? RF_WD : mem_q[RF_ADR2];
    end
  end

  assign VIOL_CNT = viol_q;
  assign LOCKED   = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_secure_reg_file.sv
module tb_secure_reg_file;

  localparam int PRIV = 31;
  localparam int PBASE = 13;
  localparam int MAXV = 3;
  localparam int COOL = 4;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [3:0]  RF_ADR1 = '0;
  logic [3:0]  RF_ADR2 = '0;
  logic [3:0]  RF_WA = '0;
  logic        RF_EN = 1'b0;
  logic [15:0] RF_WD = '0;
  logic [15:0] U_ID = '0;
  logic        UNLOCK = 1'b0;
  logic [15:0] RF_RS1;
  logic [15:0] RF_RS2;
  logic        WR_ACK;
  logic        WR_DENY;
  logic [3:0]  VIOL_CNT;
  logic        LOCKED;

  int checks = 0;
  int errors = 0;

  // Behavioural model: register contents, a locked flag, and the number of
  // cooldown cycles still to be served (nonzero means cooldown).
  logic [15:0] m_mem [16];
  bit          m_locked;
  int          m_cool;
  int          m_viol;
  bit          m_ack;
  bit          m_deny;

  secure_reg_file dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .RF_ADR1  (RF_ADR1),
    .RF_ADR2  (RF_ADR2),
    .RF_WA    (RF_WA),
    .RF_EN    (RF_EN),
    .RF_WD    (RF_WD),
    .U_ID     (U_ID),
    .UNLOCK   (UNLOCK),
    .RF_RS1   (RF_RS1),
    .RF_RS2   (RF_RS2),
    .WR_ACK   (WR_ACK),
    .WR_DENY  (WR_DENY),
    .VIOL_CNT (VIOL_CNT),
    .LOCKED   (LOCKED)
  );

  always #5 CLK = ~CLK;

  function automatic bit m_open();
    return !m_locked && (m_cool == 0);
  endfunction

  function automatic bit m_priv();
    return int'(U_ID) == PRIV;
  endfunction

  function automatic bit m_write_taken();
    int wa = int'(RF_WA);
    return RF_EN && (wa != 0) && ((wa < PBASE) || (m_open() && m_priv()));
  endfunction

  function automatic logic [15:0] exp_rd(input int adr);
    if (adr == 0) return 16'h0000;
    if (adr >= PBASE && !(m_open() && m_priv())) return 16'h0000;
    if (m_write_taken() && int'(RF_WA) == adr) return RF_WD;
    return m_mem[adr];
  endfunction

  // Model state advances on each clock edge from the pre-edge inputs. Reset clears it at once.
  initial begin : model
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    m_locked = 0; m_cool = 0; m_viol = 0; m_ack = 0; m_deny = 0;
    forever begin
      @(posedge CLK or negedge RST_N);
      if (!RST_N) begin
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        m_locked = 0; m_cool = 0; m_viol = 0; m_ack = 0; m_deny = 0;
      end else begin
        automatic bit was_open = m_open();
        automatic bit was_locked = m_locked;
        automatic int was_cool = m_cool;
        automatic bit taken = m_write_taken();
        automatic int wa = int'(RF_WA);
        m_ack = 0;
        m_deny = 0;
        if (RF_EN && wa != 0) begin
          if (taken) begin
            m_mem[wa] = RF_WD;
            m_ack = 1;
          end else begin
            m_deny = 1;
            if (was_open) begin
              m_viol = m_viol + 1;
              if (m_viol >= MAXV) m_locked = 1;
            end
          end
        end
        if (was_locked) begin
          if (UNLOCK && m_priv()) begin
            m_locked = 0;
            m_cool = COOL;
          end
        end else if (was_cool > 0) begin
          m_cool = was_cool - 1;
          if (m_cool == 0) m_viol = 0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("rs1", 32'(RF_RS1), 32'(exp_rd(int'(RF_ADR1))));
    check("rs2", 32'(RF_RS2), 32'(exp_rd(int'(RF_ADR2))));
    check("wr_ack", 32'(WR_ACK), 32'(m_ack));
    check("wr_deny", 32'(WR_DENY), 32'(m_deny));
    check("viol_cnt", 32'(VIOL_CNT), 32'(m_viol));
    check("locked", 32'(LOCKED), 32'(m_locked));
  endtask

  // Inputs change 1 ns after the rising edge. Outputs are compared on the falling edge.
  task automatic cyc(input int a1, input int a2, input int wa, input bit en,
                     input logic [15:0] wd, input int uid, input bit unl);
    @(posedge CLK);
    #1;
    RF_ADR1 = a1[3:0];
    RF_ADR2 = a2[3:0];
    RF_WA   = wa[3:0];
    RF_EN   = en;
    RF_WD   = wd;
    U_ID    = uid[15:0];
    UNLOCK  = unl;
    @(negedge CLK);
    compare_all();
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin : stim
    #2;
    check("reset_rs1", 32'(RF_RS1), 'h0);
    check("reset_ack", 32'(WR_ACK), 'h0);
    check("reset_deny", 32'(WR_DENY), 'h0);
    check("reset_viol", 32'(VIOL_CNT), 'h0);
    check("reset_locked", 32'(LOCKED), 'h0);
    #10 RST_N = 1'b1;

    // Basic write with same-cycle bypass, then a registered ACK
    cyc(5, 0, 5, 1, 16'h1234, 0, 0);
    check("r5_bypass", 32'(RF_RS1), 'h1234);
    cyc(5, 0, 0, 0, 16'h0000, 0, 0);
    check("r5_ack", 32'(WR_ACK), 'h1);
    check("r5_read", 32'(RF_RS1), 'h1234);
    check("r5_viol", 32'(VIOL_CNT), 'h0);

    // Bypass on port 2; writes to R0 are ignored
    cyc(0, 7, 7, 1, 16'hBEEF, 0, 0);
    check("r7_bypass", 32'(RF_RS2), 'hBEEF);
    cyc(0, 0, 0, 1, 16'hFFFF, 0, 0);
    check("r7_ack", 32'(WR_ACK), 'h1);
    check("r0_read", 32'(RF_RS1), 'h0);
    cyc(0, 0, 0, 0, 16'h0000, 0, 0);
    check("r0_no_ack", 32'(WR_ACK), 'h0);
    check("r0_no_deny", 32'(WR_DENY), 'h0);

    // Privileged write to a protected register; read masking by ID
    cyc(14, 0, 14, 1, 16'hA5A5, PRIV, 0);
    cyc(14, 0, 0, 0, 16'h0000, PRIV, 0);
    check("r14_ack", 32'(WR_ACK), 'h1);
    check("r14_priv_read", 32'(RF_RS1), 'hA5A5);
    cyc(14, 0, 0, 0, 16'h0000, 2, 0);
    check("r14_user_read", 32'(RF_RS1), 'h0);

    // Three violations lock the file
    cyc(0, 0, 13, 1, 16'h1111, 2, 0);
    cyc(0, 0, 13, 1, 16'h2222, 2, 0);
    check("v1_deny", 32'(WR_DENY), 'h1);
    check("v1_cnt", 32'(VIOL_CNT), 'h1);
    cyc(0, 0, 13, 1, 16'h3333, 2, 0);
    check("v2_cnt", 32'(VIOL_CNT), 'h2);
    check("v2_locked", 32'(LOCKED), 'h0);
    cyc(0, 0, 13, 1, 16'h4444, PRIV, 0);
    check("v3_cnt", 32'(VIOL_CNT), 'h3);
    check("v3_locked", 32'(LOCKED), 'h1);
    cyc(0, 0, 3, 1, 16'h0033, PRIV, 0);
    check("locked_priv_deny", 32'(WR_DENY), 'h1);
    check("locked_cnt_sat", 32'(VIOL_CNT), 'h3);
    cyc(3, 0, 0, 0, 16'h0000, PRIV, 0);
    check("locked_r3_ack", 32'(WR_ACK), 'h1);
    check("locked_r3_read", 32'(RF_RS1), 'h0033);

    // Unlock: an unprivileged request is ignored, a privileged one starts the cooldown
    cyc(0, 0, 0, 0, 16'h0000, 2, 1);
    cyc(0, 0, 0, 0, 16'h0000, 2, 0);
    check("bad_unlock", 32'(LOCKED), 'h1);
    cyc(0, 0, 0, 0, 16'h0000, PRIV, 1);
    for (int k = 0; k < COOL; k++) begin
      cyc(14, 0, 15, 1, 16'h0F0F, PRIV, 0);
      check("cool_locked", 32'(LOCKED), 'h0);
      check("cool_mask", 32'(RF_RS1), 'h0);
      if (k > 0) check("cool_deny", 32'(WR_DENY), 'h1);
    end
    cyc(14, 0, 15, 1, 16'h5A5A, PRIV, 0);
    check("cool_end_deny", 32'(WR_DENY), 'h1);
    check("cool_end_viol", 32'(VIOL_CNT), 'h0);
    check("open_r14", 32'(RF_RS1), 'hA5A5);
    cyc(15, 0, 0, 0, 16'h0000, PRIV, 0);
    check("r15_ack", 32'(WR_ACK), 'h1);
    check("r15_read", 32'(RF_RS1), 'h5A5A);

    // Asynchronous reset in the middle of the cooldown
    for (int k = 0; k < 3; k++) cyc(0, 0, 13, 1, 16'h1, 2, 0);
    cyc(0, 0, 0, 0, 16'h0, PRIV, 1);
    cyc(5, 14, 0, 0, 16'h0, PRIV, 0);
    check("pre_rst_r5", 32'(RF_RS1), 'h1234);
    #1 RST_N = 1'b0;
    #1;
    check("arst_r5", 32'(RF_RS1), 'h0);
    check("arst_locked", 32'(LOCKED), 'h0);
    check("arst_viol", 32'(VIOL_CNT), 'h0);
    compare_all();
    #1 RST_N = 1'b1;
    cyc(14, 5, 0, 0, 16'h0, PRIV, 0);
    check("post_rst_r14", 32'(RF_RS1), 'h0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      automatic int wa = ($urandom_range(0, 1) != 0) ? int'($urandom_range(12, 15))
                                                      : int'($urandom_range(0, 15));
      automatic int uid = ($urandom_range(0, 1) != 0) ? PRIV : int'($urandom_range(0, 40));
      cyc(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), wa,
          ($urandom_range(0, 3) != 0), 16'($urandom), uid, ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 299) == 0) begin
        #1 RST_N = 1'b0;
        #1 compare_all();
        #1 RST_N = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
